// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: clocked stimulus master for a combinational ALU.
// Latches one operand set on an accepted start, then walks alu_ctrl_o through
// every op selected in the mask (lowest index first). Each op is held for
// SETTLE_CYC cycles before alu_y_i is captured. The captured result is then
// offered on a valid/ready stream.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   start_i, abort_i              begin sweep (idle only) / cancel sweep
//   op_a_i, op_b_i, op_num_i      operands latched on accepted start
//   op_mask_i                     bit i set -> run op i
//   alu_ctrl_o, alu_num_o,
//   alu_a_o, alu_b_o              registered drive to the ALU
//   alu_y_i                       ALU result (combinational from alu_*_o)
//   res_valid_o, res_ready_i,
//   res_data_o, res_ctrl_o        result stream
//   busy_o                        high whenever not idle
//   done_o                        one-cycle pulse on normal completion
module alu_sweep_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [4:0]       op_num_i,
    input  logic [7:0]       op_mask_i,
    output logic [2:0]       alu_ctrl_o,
    output logic [4:0]       alu_num_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_y_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic [2:0]       res_ctrl_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold, StFinish} state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [7:0]       mask_q, mask_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [4:0]       alu_num_q, alu_num_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [2:0]       res_ctrl_q, res_ctrl_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Returns {found, index} of the lowest set mask bit at index >= lo.
    function automatic logic [3:0] find_op(input logic [7:0] mask, input logic [3:0] lo);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0] first_op;
    logic [3:0] next_op;

    assign first_op = find_op(op_mask_i, 4'd0);
    assign next_op  = find_op(mask_q, {1'b0, alu_ctrl_q} + 4'd1);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_num_d   = alu_num_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ctrl_d  = res_ctrl_q;

        case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    alu_a_d   = op_a_i;
                    alu_b_d   = op_b_i;
                    alu_num_d = op_num_i;
                    mask_d    = op_mask_i;
                    if (first_op[3]) begin
                        alu_ctrl_d = first_op[2:0];
                        cnt_d      = CntLoad;
                        state_d    = StSettle;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_data_d  = alu_y_i;
                    res_ctrl_d  = alu_ctrl_q;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                // res_valid_q is always high here, so ready alone means transfer.
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    if (next_op[3]) begin
                        alu_ctrl_d = next_op[2:0];
                        cnt_d      = CntLoad;
                        state_d    = StSettle;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d     = StIdle;
            res_valid_d = 1'b0;
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StFinish);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            cnt_q       <= '0;
            alu_ctrl_q  <= '0;
            alu_num_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ctrl_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_num_q   <= alu_num_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ctrl_q  <= res_ctrl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign alu_ctrl_o  = alu_ctrl_q;
    assign alu_num_o   = alu_num_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_ctrl_o  = res_ctrl_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
